// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: RISC-V integer register file with an integrated busy-bit
// scoreboard. NRD combinational read ports, one write port, optional
// write-to-read forwarding, and per-register busy tracking for hazard checks.
// x0 reads as zero, is never written and never becomes busy.
module rv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic [AW:0]         n_busy
);

  localparam logic BYP_EN = (BYPASS != 0);

  // Architectural state
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] busy_eff;

  // Qualified writeback: x0 writes are dropped. Gating with rst keeps the
  // forwarding path quiet while reset is held, so all reads return zero.
  logic wr_ok;
  assign wr_ok = wen & ~rst & (waddr != '0);

  // Issue qualification: an issue only takes effect when the destination is
  // free (after forwarding) and no squash is in progress.
  logic set_ok;
  assign set_ok = iss_valid & iss_ready & (iss_rd != '0) & ~flush;

  // Effective busy: a register being written back this cycle is treated as
  // already free when forwarding is enabled.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy_eff
    assign busy_eff[gi] = busy[gi] & ~(BYP_EN & wr_ok & (waddr == AW'(gi)));
  end

  // Read ports: x0 is constant zero; a matching writeback is forwarded when
  // enabled, otherwise the stored value is returned.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr[gi*AW +: AW];
    assign hit = BYP_EN & wr_ok & (waddr == ra);
    assign rdata[gi*XLEN +: XLEN] = (ra == '0) ? '0 :
                                    hit        ? wdata : rf[ra];
    assign rbusy[gi] = (ra != '0) & busy_eff[ra];
  end

  // A destination is free when it is x0 or not (effectively) busy.
  assign iss_ready = (iss_rd == '0) | ~busy_eff[iss_rd];

  // Register array write; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_ok) begin
      rf[waddr] <= wdata;
    end
  end

  // Busy next-state: flush wins over everything; otherwise the clear from
  // writeback is applied first and the set from issue second, so a same-
  // register clear/set leaves the bit set for the new producer.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_ok) begin
        busy_next[waddr] = 1'b0;
      end
      if (set_ok) begin
        busy_next[iss_rd] = 1'b1;
      end
    end
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Population count of the registered busy vector.
  always_comb begin
    n_busy = '0;
    for (int i = 0; i < NREG; i++) begin
      n_busy = n_busy + (AW+1)'(busy[i]);
    end
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: scoreboard bench for rv_regfile_sb. Two instances share
// the stimulus, one with forwarding enabled and one without. Expected
// outputs are pushed into per-instance queues by the stimulus process and a
// monitor compares them on the falling edge.
module tb_rv_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wen = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic                flush = 1'b0;

  logic [NRD*XLEN-1:0] rdata0, rdata1;
  logic [NRD-1:0]      rbusy0, rbusy1;
  logic                ready0, ready1;
  logic [AW:0]         nbusy0, nbusy1;

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(ready0), .flush(flush), .n_busy(nbusy0)
  );

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(ready1), .flush(flush), .n_busy(nbusy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  id;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                ready;
    logic [AW:0]         nbusy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state per instance: index 0 = no forwarding, 1 = forwarding.
  logic [XLEN-1:0] m_rf   [2][NREG];
  bit              m_busy [2][NREG];

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  task automatic check_field(input string name, input int id, input int b,
                             input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s txn=%0d bypass=%0d got=%h expected=%h", name, id, b, act, exp);
    end
  endtask

  task automatic check_all(input int b, input exp_t e, input logic [63:0] rd,
                           input logic [1:0] rb, input logic ry, input logic [5:0] nb);
    check_field("rdata", e.id, b, rd, e.rdata);
    check_field("rbusy", e.id, b, 64'(rb), 64'(e.rbusy));
    check_field("iss_ready", e.id, b, 64'(ry), 64'(e.ready));
    check_field("n_busy", e.id, b, 64'(nb), 64'(e.nbusy));
  endtask

  // Monitor: outputs are combinational, so each queued expectation is
  // checked on the falling edge of the cycle its stimulus was applied in.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      $display("[TB] txn %0d bypass=0 raddr=%h rdata=%h rbusy=%b ready=%b n_busy=%0d",
               e.id, raddr, rdata0, rbusy0, ready0, nbusy0);
      check_all(0, e, rdata0, rbusy0, ready0, nbusy0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      $display("[TB] txn %0d bypass=1 raddr=%h rdata=%h rbusy=%b ready=%b n_busy=%0d",
               e.id, raddr, rdata1, rbusy1, ready1, nbusy1);
      check_all(1, e, rdata1, rbusy1, ready1, nbusy1);
    end
  end

  // Apply one cycle of stimulus, predict both instances' outputs from the
  // reference state, then advance the reference state across the next edge.
  task automatic step(input bit r, input bit w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a0,
                      input logic [4:0] a1, input bit v, input logic [4:0] rd,
                      input bit f);
    @(posedge clk);
    #1;
    rst = r; wen = w; waddr = wa; wdata = wd; raddr = {a1, a0};
    iss_valid = v; iss_rd = rd; flush = f;
    txn++;
    for (int b = 0; b < 2; b++) begin
      exp_t        e;
      logic [4:0]  a;
      bit          hit;
      bit          ready;
      bit          wr;
      int          cnt;
      e.id = txn;
      if (r) begin
        for (int i = 0; i < NREG; i++) begin
          m_rf[b][i] = '0;
          m_busy[b][i] = 0;
        end
        e.rdata = '0; e.rbusy = '0; e.ready = 1'b1; e.nbusy = '0;
      end else begin
        wr = w && (wa != 0);
        for (int k = 0; k < NRD; k++) begin
          a = (k == 0) ? a0 : a1;
          hit = (b == 1) && wr && (wa == a);
          if (a == 0) begin
            e.rdata[k*XLEN +: XLEN] = '0;
            e.rbusy[k] = 1'b0;
          end else begin
            e.rdata[k*XLEN +: XLEN] = hit ? wd : m_rf[b][a];
            e.rbusy[k] = m_busy[b][a] && !hit;
          end
        end
        ready = (rd == 0) || !(m_busy[b][rd] && !((b == 1) && wr && (wa == rd)));
        e.ready = ready;
        cnt = 0;
        for (int i = 0; i < NREG; i++) cnt += int'(m_busy[b][i]);
        e.nbusy = 6'(cnt);
        // state after the coming rising edge
        if (wr) m_rf[b][wa] = wd;
        if (f) begin
          for (int i = 0; i < NREG; i++) m_busy[b][i] = 0;
        end else begin
          if (wr) m_busy[b][wa] = 0;
          if (v && ready && rd != 0) m_busy[b][rd] = 1;
        end
      end
      if (b == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NREG; i++) begin
        m_rf[b][i] = '0;
        m_busy[b][i] = 0;
      end

    // reset held with a matching writeback: forwarding must stay silent
    step(1, 1, 5'd5, 32'hFFFF_0000, 5'd5, 5'd5, 0, 5'd0, 0);
    // write/read, x0 write dropped
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 0, 5'd0, 0);
    step(0, 0, 5'd0, 32'h0,         5'd5, 5'd0, 0, 5'd0, 0);
    step(0, 1, 5'd0, 32'h0000_1234, 5'd5, 5'd0, 0, 5'd0, 0);
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 0, 5'd0, 0);
    // forwarding vs stored value
    step(0, 1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 0, 5'd0, 0);
    step(0, 0, 5'd0, 32'h0,         5'd7, 5'd0, 0, 5'd0, 0);
    // scoreboard set/clear on x3
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd3, 0);
    step(0, 0, 5'd0, 32'h0,         5'd3, 5'd3, 0, 5'd3, 0);
    step(0, 1, 5'd3, 32'h0000_0033, 5'd3, 5'd0, 0, 5'd3, 0);
    step(0, 0, 5'd0, 32'h0,         5'd3, 5'd0, 0, 5'd3, 0);
    // same-register clear and set on x4
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd4, 0);
    step(0, 1, 5'd4, 32'h0000_0044, 5'd4, 5'd0, 1, 5'd4, 0);
    step(0, 0, 5'd0, 32'h0,         5'd4, 5'd0, 0, 5'd4, 0);
    // flush together with an issue
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd1, 0);
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd2, 0);
    step(0, 0, 5'd0, 32'h0,         5'd0, 5'd0, 1, 5'd9, 0);
    step(0, 0, 5'd0, 32'h0,         5'd1, 5'd9, 1, 5'd10, 1);
    step(0, 0, 5'd0, 32'h0,         5'd10, 5'd5, 0, 5'd10, 0);
    // reset raised mid-cycle after writes
    step(1, 1, 5'd5, 32'h1111_2222, 5'd5, 5'd7, 1, 5'd5, 0);
    step(0, 0, 5'd0, 32'h0,         5'd5, 5'd7, 0, 5'd5, 0);

    // randomized traffic, addresses biased towards a few registers
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, a0, a1, rd;
      bit r, w, v, f;
      r  = ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 1) == 1);
      v  = ($urandom_range(0, 1) == 1);
      f  = ($urandom_range(0, 24) == 0);
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      step(r, w, wa, $urandom, a0, a1, v, rd, f);
    end

    repeat (3) @(posedge clk);
    tests++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain got=%0d pending expected=0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
- Parametrised RISC-V integer register file with a built-in scoreboard, for the pipelined core.
- Provides NRD combinational read ports and one write port, with optional write-to-read bypass.
- Keeps one busy bit per register, set at issue and cleared at writeback, so decode can detect RAW/WAW hazards without a separate scoreboard.
- x0 is hardwired to zero and never becomes busy.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREG), register address width (derived; do not override).
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see only stored state.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wen  in  1  writeback enable
- waddr  in  AW  writeback register index
- wdata  in  XLEN  writeback data
- raddr  in  NRD*AW  read indices; port k uses bits [k*AW +: AW]
- rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- rbusy  out  NRD  1 = port k's register has an outstanding producer
- iss_valid  in  1  an instruction writing iss_rd is issuing this cycle
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  1 = iss_rd is free (no WAW hazard)
- flush  in  1  clear all busy bits (pipeline squash)
- n_busy  out  AW+1  number of set busy bits

Behaviour:
- Reset (async, rst=1): every rf entry = 0 and every busy bit = 0, applied immediately with no clock needed.
  - Outputs while in reset: rdata all 0, rbusy = 0, n_busy = 0, iss_ready = 1.
  - Reset asserted mid-operation discards all pending writes and busy state.
- Write: on posedge clk, if wen and waddr != 0, rf[waddr] <= wdata.
  - A write to x0 is dropped and has no effect on busy state.
- Read: combinational, zero latency.
  - raddr = 0 gives rdata = 0 and rbusy = 0, regardless of wen or busy state.
  - If BYPASS=1, wen=1 and waddr == raddr_k != 0: rdata_k = wdata, and the register counts as freed this cycle.
  - Otherwise rdata_k = rf[raddr_k].
- Effective busy: busy_eff[r] = busy[r] & ~(BYPASS & wen & waddr==r).
  - rbusy_k = busy_eff[raddr_k].
  - With BYPASS=0, busy_eff = busy (the consumer waits one more cycle).
- iss_ready = (iss_rd == 0) | ~busy_eff[iss_rd]. It does not depend on iss_valid.
- Busy bit update, on posedge clk, in priority order:
  1. flush=1: all busy bits <= 0. This applies in the same cycle as any iss_valid; an issue during flush does not set a bit. rf writes still occur.
  2. Otherwise, set = iss_valid & iss_ready & iss_rd != 0.
  3. If set and wen hit the same register: busy stays 1 (the new producer wins).
  4. Otherwise, wen (waddr != 0) clears busy[waddr] and set sets busy[iss_rd]. A clear and a set on different registers in one cycle are independent.
- iss_valid while iss_ready=0 is ignored (no set); the issuing stage must stall.
- wen to a non-busy register is legal: the data is written and busy is unchanged.
- n_busy is the combinational popcount of the registered busy vector (not busy_eff). Range 0..NREG-1.
- Multiple read ports may address the same register; each returns an identical result.

Test Plan:
- Reset: pulse rst mid-clock after prior writes → rdata=0 for all indices, n_busy=0, iss_ready=1, with no clock edge required.
- Write/read with x0: wen, waddr=5, wdata=0xDEADBEEF, then raddr0=5 → 0xDEADBEEF; write 0x1234 to x0 → raddr1=0 reads 0, rbusy=0.
- Bypass: BYPASS=1, wen, waddr=7, wdata=0xA5A5A5A5, raddr0=7 in the same cycle → rdata0=0xA5A5A5A5. Repeat with BYPASS=0 → old value returned.
- Scoreboard:
  - Issue iss_rd=3 → next cycle rbusy for x3 = 1, n_busy=1, iss_ready for rd=3 is 0.
  - wen waddr=3 → bypass visible the same cycle; busy clears at the edge, n_busy=0.
- Simultaneous set/clear: busy[4]=1; in one cycle wen waddr=4 and iss_valid iss_rd=4 (iss_ready=1 via bypass) → busy[4] stays 1, n_busy unchanged.
- Flush: set busy on x1, x2, x9 (n_busy=3); flush together with iss_valid iss_rd=10 → all busy 0 and x10 not set. Register contents retained.
